// File: rtl/dbg_mem_master.sv
// Debug memory master: halts the CPU, performs one debug word access on the
// shared data-memory bus per command, and returns a one-cycle response.
// The CPU keeps the bus while not halted; while halted its writes are blocked.
module dbg_mem_master #(
  parameter int          HALT_SETTLE = 4,
  parameter logic [31:0] ADDR_MAX    = 32'd9
) (
  input  logic        CK_REF,
  input  logic        RST_N,
  // debug command channel
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WRITE,
  input  logic        CMD_LAST,
  input  logic [31:0] CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  // response channel
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  // CPU control
  output logic        HALT,
  // CPU-side memory bus
  input  logic [31:0] CPU_ADDR_BUS,
  input  logic [31:0] CPU_DATA_OUT_BUS,
  input  logic        CPU_READ_WRN,
  // memory-side bus
  output logic [31:0] MEM_ACCESS_ADDRESS_BUS,
  output logic [31:0] MEM_ACCESS_DATA_OUT_BUS,
  output logic        MEM_ACCESS_READ_WRN,
  input  logic [31:0] MEM_ACCESS_DATA_IN_BUS
);

  localparam int CW = 16;
  // A settle length of zero still needs one SETTLE cycle to sequence the FSM.
  localparam logic [CW-1:0] CNT_INIT = (HALT_SETTLE < 1) ? CW'(1) : CW'(HALT_SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_ACCESS,
    S_RESP
  } state_e;

  typedef struct packed {
    logic        write;
    logic        last;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  state_e        state_q, state_d;
  logic          halt_q, halt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cmd_t          cmd_q, cmd_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;

  logic          addr_err;

  // Out-of-range debug addresses never reach memory.
  assign addr_err  = (cmd_q.addr > ADDR_MAX);

  assign CMD_READY = (state_q == S_IDLE);
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ERR   = rsp_err_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign HALT      = halt_q;

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      halt_q      <= 1'b0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state logic: accept, settle (new session only), access, respond.
  always_comb begin
    state_d     = state_q;
    halt_d      = halt_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          cmd_d.write = CMD_WRITE;
          cmd_d.last  = CMD_LAST;
          cmd_d.addr  = CMD_ADDR;
          cmd_d.wdata = CMD_WDATA;
          if (halt_q) begin
            // Session already open: CPU is parked, go straight to the bus.
            state_d = S_ACCESS;
          end else begin
            halt_d  = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = S_ACCESS;
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
      end
      S_ACCESS: begin
        // Response registers load here so RSP_* are valid during RESP and
        // hold their value afterwards.
        rsp_valid_d = 1'b1;
        rsp_err_d   = addr_err;
        rsp_rdata_d = (!cmd_q.write && !addr_err) ? MEM_ACCESS_DATA_IN_BUS : 32'h0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (cmd_q.last) halt_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus mux: CPU owns the bus unless halted; while halted only ACCESS writes.
  always_comb begin
    MEM_ACCESS_ADDRESS_BUS  = CPU_ADDR_BUS;
    MEM_ACCESS_DATA_OUT_BUS = CPU_DATA_OUT_BUS;
    MEM_ACCESS_READ_WRN     = CPU_READ_WRN;
    if (halt_q) begin
      if (state_q == S_ACCESS) begin
        MEM_ACCESS_ADDRESS_BUS  = cmd_q.addr;
        MEM_ACCESS_DATA_OUT_BUS = cmd_q.wdata;
        MEM_ACCESS_READ_WRN     = !(cmd_q.write && !addr_err);
      end else begin
        MEM_ACCESS_READ_WRN     = 1'b1;
      end
    end
  end

endmodule
